mc_ctrl: RTL and testbench

Multi-cycle sequencer for the single-issue ALU datapath. Fetches instructions over a request/ready memory handshake, holds each instruction in an instruction register that drives the instruction decoder, then steps the register-file read, ALU execute and write-back phases. Sits at the top of the core, between instruction memory and the decoder/register-file/ALU datapath. Halts on an all-zero word (clean) or on an instruction the decoder reports as undefined (error).

---
 rtl/mc_pkg.sv | 27 ++
 rtl/mc_ctrl.sv | 117 +++++++++++
 tb/tb_mc_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared state encodings and constants for the
// multi-cycle sequencer and the datapath beside it.
package mc_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_FETCH  = 3'd1;
   localparam state_t S_DECODE = 3'd2;
   localparam state_t S_EXEC   = 3'd3;
   localparam state_t S_WB     = 3'd4;
   localparam state_t S_HALT   = 3'd5;

   typedef enum logic [3:0] {
      OP_AND   = 4'd0,
      OP_OR    = 4'd1,
      OP_ADD   = 4'd2,
      OP_SUB   = 4'd6,
      OP_SLT   = 4'd7,
      OP_NOR   = 4'd12,
      OP_UNDEF = 4'd15
   } alu_op_e;

   localparam int unsigned PC_STEP = 4;
   localparam logic [31:0] HALT_WORD = 32'h0;

endpackage

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle fetch/decode/execute/write-back sequencer.
// Strobes are decoded from state; instr only loads on an accepted fetch.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned AWIDTH = 32,
   parameter logic [AWIDTH-1:0] START_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              imem_req,
   output logic [AWIDTH-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [DWIDTH-1:0] imem_rdata,
   output logic [DWIDTH-1:0] instr,
   input  logic [3:0]        dec_op,
   input  logic [4:0]        dec_rdst_id,
   output logic              rf_re,
   output logic              alu_en,
   output logic              rf_we,
   output logic [AWIDTH-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic              err,
   output logic [31:0]       retired
);

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] pc_q, pc_d;
   logic [DWIDTH-1:0] instr_q, instr_d;
   logic [31:0]       retired_q, retired_d;
   logic              err_q, err_d;

   logic is_halt_word;
   logic is_undef;

   assign is_halt_word = (instr_q == DWIDTH'(HALT_WORD));
   assign is_undef     = (dec_op == 4'(OP_UNDEF));

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      err_d     = err_q;
      unique case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               pc_d      = START_PC;
               retired_d = '0;
               err_d     = 1'b0;
               state_d   = S_FETCH;
            end
         end
         S_FETCH: begin
            if (imem_ready) begin
               instr_d = imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            // An all-zero word wins over the decoder's undefined flag
            if (is_halt_word) begin
               state_d = S_HALT;
            end else if (is_undef) begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_WB;
         end
         S_WB: begin
            pc_d      = pc_q + AWIDTH'(PC_STEP);
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= START_PC;
         instr_q   <= '0;
         retired_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
         err_q     <= err_d;
      end
   end

   assign imem_req  = (state_q == S_FETCH);
   assign imem_addr = pc_q;
   assign instr     = instr_q;
   assign rf_re     = (state_q == S_DECODE) && !is_halt_word && !is_undef;
   assign alu_en    = (state_q == S_EXEC);
   assign rf_we     = (state_q == S_WB) && (dec_rdst_id != 5'd0);
   assign pc        = pc_q;
   assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                      (state_q == S_EXEC)  || (state_q == S_WB);
   assign halted    = (state_q == S_HALT);
   assign err       = err_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed vectors against mc_ctrl with a tiny
// instruction memory and a MIPS-style decoder stand-in.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start2;
   logic        imem_ready;

   logic        imem_req, imem_req2;
   logic [31:0] imem_addr, imem_addr2;
   logic [31:0] imem_rdata, imem_rdata2;
   logic [31:0] instr, instr2;
   logic [3:0]  dec_op, dec_op2;
   logic [4:0]  dec_rd, dec_rd2;
   logic        rf_re, alu_en, rf_we, busy, halted, err;
   logic        rf_re2, alu_en2, rf_we2, busy2, halted2, err2;
   logic [31:0] pc, pc2, retired, retired2;

   logic [31:0] mem [0:15];

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [31:0] we_mask;
   int          re_cnt, we_cnt;

   always #5 clk = ~clk;

   function automatic logic [3:0] dec_op_f(input logic [31:0] w);
      if (w[31:26] == 6'h3F) return 4'hF;
      if (w[31:26] == 6'h00 && w[5:0] == 6'h22) return 4'd6;
      return 4'd2;
   endfunction

   function automatic logic [4:0] dec_rd_f(input logic [31:0] w);
      return (w[31:26] == 6'h00) ? w[15:11] : w[20:16];
   endfunction

   assign imem_rdata  = mem[imem_addr[5:2]];
   assign imem_rdata2 = mem[imem_addr2[5:2]];
   assign dec_op      = dec_op_f(instr);
   assign dec_rd      = dec_rd_f(instr);
   assign dec_op2     = dec_op_f(instr2);
   assign dec_rd2     = dec_rd_f(instr2);

   mc_ctrl u_dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instr(instr), .dec_op(dec_op), .dec_rdst_id(dec_rd),
      .rf_re(rf_re), .alu_en(alu_en), .rf_we(rf_we),
      .pc(pc), .busy(busy), .halted(halted),
      .err(err), .retired(retired)
   );

   mc_ctrl #(.START_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(rst), .start(start2),
      .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_ready(1'b1), .imem_rdata(imem_rdata2),
      .instr(instr2), .dec_op(dec_op2), .dec_rdst_id(dec_rd2),
      .rf_re(rf_re2), .alu_en(alu_en2), .rf_we(rf_we2),
      .pc(pc2), .busy(busy2), .halted(halted2),
      .err(err2), .retired(retired2)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_halt();
      for (int i = 0; i < 60; i++) begin
         if (halted) break;
         tick();
      end
      chk("halt_wait", 32'(halted), 32'd1);
   endtask

   task automatic load_prog();
      mem[0] = 32'h2001_0005;
      mem[1] = 32'h0021_1020;
      mem[2] = 32'h0041_1822;
      mem[3] = 32'h0000_0000;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      start2 = 1'b0;
      imem_ready = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[15] = 32'h2001_0005;
      #12;
      chk("rst_strobes", 32'({imem_req, rf_re, alu_en, rf_we, busy, halted}), 32'd0);
      chk("rst_pc", pc, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_ret", retired, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_pc2", pc2, 32'hFFFF_FFFC);
      @(negedge clk);
      rst = 1'b0;

      // PC wrap from START_PC = 2^32-4
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      chk("wrap_req1", 32'(imem_req2), 32'd1);
      chk("wrap_addr1", imem_addr2, 32'hFFFF_FFFC);
      repeat (4) tick();
      chk("wrap_req2", 32'(imem_req2), 32'd1);
      chk("wrap_addr2", imem_addr2, 32'd0);
      chk("wrap_ret", retired2, 32'd1);

      // Three-instruction program, zero-wait memory
      load_prog();
      start = 1'b1;
      tick();
      start = 1'b0;
      we_mask = '0;
      re_cnt = 0;
      for (int c = 1; c <= 13; c++) begin
         if (rf_we) we_mask[c] = 1'b1;
         if (rf_re) re_cnt++;
         tick();
      end
      tick();
      chk("p1_we_mask", we_mask, 32'h0000_1110);
      chk("p1_re_cnt", 32'(re_cnt), 32'd3);
      chk("p1_halted", 32'(halted), 32'd1);
      chk("p1_busy", 32'(busy), 32'd0);
      chk("p1_err", 32'(err), 32'd0);
      chk("p1_ret", retired, 32'd3);
      chk("p1_pc", pc, 32'd12);

      // Second fetch stalls three cycles; start while busy is ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      imem_ready = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         chk("st_req", 32'(imem_req), 32'd1);
         chk("st_addr", imem_addr, 32'd4);
         if (k == 1) start = 1'b1;
         tick();
         start = 1'b0;
      end
      imem_ready = 1'b1;
      chk("st_req_acc", 32'(imem_req), 32'd1);
      chk("st_addr_acc", imem_addr, 32'd4);
      chk("st_ret_mid", retired, 32'd1);
      tick();
      tick();
      tick();
      chk("st_we_c11", 32'(rf_we), 32'd1);
      tick();
      chk("st_pc_c12", pc, 32'd8);
      chk("st_fetch_c12", 32'(imem_req), 32'd1);
      wait_halt();
      chk("st_ret", retired, 32'd3);

      // Undefined opcode at pc=8
      mem[2] = 32'hFC00_0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      re_cnt = 0;
      we_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         if (rf_re) re_cnt++;
         if (rf_we) we_cnt++;
         if (c == 10) chk("ud_dec_halted", 32'(halted), 32'd0);
         if (c == 11) chk("ud_halted", 32'(halted), 32'd1);
         tick();
      end
      chk("ud_re_cnt", 32'(re_cnt), 32'd2);
      chk("ud_we_cnt", 32'(we_cnt), 32'd2);
      chk("ud_err", 32'(err), 32'd1);
      chk("ud_ret", retired, 32'd2);
      chk("ud_pc", pc, 32'd8);
      chk("ud_instr", instr, 32'hFC00_0000);

      // Restart from HALT clears err
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rs_err", 32'(err), 32'd0);
      chk("rs_pc", pc, 32'd0);
      chk("rs_ret", retired, 32'd0);
      chk("rs_req", 32'(imem_req), 32'd1);
      wait_halt();

      // Write to register 0 is suppressed
      mem[0] = 32'h2000_0005;
      mem[1] = 32'h0000_0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("r0_re", 32'(rf_re), 32'd1);
      tick();
      chk("r0_alu", 32'(alu_en), 32'd1);
      tick();
      chk("r0_we", 32'(rf_we), 32'd0);
      tick();
      chk("r0_ret", retired, 32'd1);
      wait_halt();

      // Reset during EXEC of the second instruction
      load_prog();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      chk("ar_alu_pre", 32'(alu_en), 32'd1);
      chk("ar_ret_pre", retired, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("ar_strobes", 32'({imem_req, rf_re, alu_en, rf_we, busy, halted}), 32'd0);
      chk("ar_pc", pc, 32'd0);
      chk("ar_ret", retired, 32'd0);
      chk("ar_instr", instr, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("ar_idle", 32'({rf_we, busy}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
